// File: rtl/timing_pkg.sv
// Shared types and limits for the timing ring phase generator.
package timing_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2
    } ring_state_e;

    localparam int MAX_PHASES = 16;

endpackage

// File: rtl/timing_ring_edge_det.sv
// Rising-edge detector with a registered last value; no edge is reported
// until one clock has been observed after reset.
module edge_det (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_sig,
    output logic o_rise
);

    logic last_q;
    logic valid_q;

    // NOTE: sequential state always uses non-blocking assignments.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            last_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            last_q  <= i_sig;
            valid_q <= 1'b1;
        end
    end

    // valid_q masks the first post-reset clock so a held-high input is not an edge
    assign o_rise = valid_q & i_sig & ~last_q;

endmodule

// File: rtl/timing_ring.sv
// Ring of PHASES non-overlapping phase pulses, WIDTH clocks high, GAP clocks apart.
// Define TIMING_RING_STEP_EN to add single-step control (i_step_mode, i_step).
module timing_ring
    import timing_pkg::*;
#(
    parameter int PHASES = 4,
    parameter int WIDTH  = 2,
    parameter int GAP    = 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic              i_dc_stop,
`ifdef TIMING_RING_STEP_EN
    input  logic              i_step_mode,
    input  logic              i_step,
`endif
    output logic [PHASES-1:0] o_phase,
    output logic              o_running,
    output logic              o_cycle_end
);

    localparam int IDX_W   = $clog2(PHASES);
    localparam int CNT_MAX = (WIDTH > GAP) ? WIDTH : GAP;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    if (PHASES < 2 || PHASES > MAX_PHASES || WIDTH < 1 || GAP < 1) begin : g_bad_params
        $error("timing_ring: parameter out of range");
    end

    ring_state_e      state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stop_q, stop_d;

    logic start_rise;
    logic advance;
    logic pulse_done;
    logic gap_done;
    logic last_phase;

    edge_det u_start_det (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_sig   (i_start),
        .o_rise  (start_rise)
    );

`ifdef TIMING_RING_STEP_EN
    logic step_rise;

    edge_det u_step_det (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_sig   (i_step),
        .o_rise  (step_rise)
    );

    assign advance = ~i_step_mode | step_rise;
`else
    assign advance = 1'b1;
`endif

    assign pulse_done = (cnt_q == CNT_W'(WIDTH - 1));
    assign gap_done   = (cnt_q == CNT_W'(GAP - 1));
    assign last_phase = (idx_q == IDX_W'(PHASES - 1));

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        stop_d  = stop_q;

        case (state_q)
            ST_IDLE: begin
                if (start_rise) begin
                    state_d = ST_PULSE;
                    idx_d   = '0;
                    cnt_d   = '0;
                    stop_d  = i_stop;
                end
            end
            ST_PULSE: begin
                stop_d = stop_q | i_stop;
                if (pulse_done) begin
                    state_d = ST_GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_GAP: begin
                stop_d = stop_q | i_stop;
                if (!gap_done) begin
                    cnt_d = cnt_q + 1'b1;
                end else if (advance) begin
                    cnt_d = '0;
                    if (last_phase) begin
                        idx_d = '0;
                        if (stop_q | i_stop) begin
                            state_d = ST_IDLE;
                            stop_d  = 1'b0;
                        end else begin
                            state_d = ST_PULSE;
                        end
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_PULSE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
                cnt_d   = '0;
                stop_d  = 1'b0;
            end
        endcase

        // Immediate stop overrides everything except reset
        if (!i_dc_stop) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            cnt_d   = '0;
            stop_d  = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            stop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            stop_q  <= stop_d;
        end
    end

    // Outputs decode registered state only, so one-hot and gap spacing hold by construction
    assign o_phase     = (state_q == ST_PULSE) ? (PHASES'(1) << idx_q) : '0;
    assign o_running   = (state_q != ST_IDLE);
    assign o_cycle_end = (state_q == ST_GAP) & gap_done & last_phase & advance;

endmodule

// File: tb/tb_timing_ring.sv
// Directed self-checking bench for timing_ring (PHASES=4, WIDTH=2, GAP=1).
// Step-mode vectors are compiled in when TIMING_RING_STEP_EN is defined.
module tb_timing_ring;

    logic       clk;
    logic       i_reset;
    logic       i_start;
    logic       i_stop;
    logic       i_dc_stop;
    logic [3:0] o_phase;
    logic       o_running;
    logic       o_cycle_end;
`ifdef TIMING_RING_STEP_EN
    logic       i_step_mode;
    logic       i_step;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // One full ring cycle, sampled one clock after the start edge is taken.
    logic [3:0] exp_phase [12] = '{4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h0,
                                   4'h4, 4'h4, 4'h0, 4'h8, 4'h8, 4'h0};

    timing_ring #(
        .PHASES (4),
        .WIDTH  (2),
        .GAP    (1)
    ) dut (
        .i_clk       (clk),
        .i_reset     (i_reset),
        .i_start     (i_start),
        .i_stop      (i_stop),
        .i_dc_stop   (i_dc_stop),
`ifdef TIMING_RING_STEP_EN
        .i_step_mode (i_step_mode),
        .i_step      (i_step),
`endif
        .o_phase     (o_phase),
        .o_running   (o_running),
        .o_cycle_end (o_cycle_end)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock and settle 1ns past the edge before sampling or driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_phase"}, {28'd0, o_phase}, 32'h0);
        check({tag, "_run"}, {31'd0, o_running}, 32'h0);
        check({tag, "_end"}, {31'd0, o_cycle_end}, 32'h0);
    endtask

    task automatic check_step(input string tag, input int k, input logic [3:0] ph,
                              input logic run, input logic cend);
        check($sformatf("%s_ph%0d", tag, k), {28'd0, o_phase}, {28'd0, ph});
        check($sformatf("%s_run%0d", tag, k), {31'd0, o_running}, {31'd0, run});
        check($sformatf("%s_end%0d", tag, k), {31'd0, o_cycle_end}, {31'd0, cend});
    endtask

    initial begin
        i_reset   = 1'b1;
        i_start   = 1'b0;
        i_stop    = 1'b0;
        i_dc_stop = 1'b1;
`ifdef TIMING_RING_STEP_EN
        i_step_mode = 1'b0;
        i_step      = 1'b0;
`endif
        repeat (3) tick();
        check_idle("reset");
        i_reset = 1'b0;
        repeat (2) tick();
        check_idle("post_reset");

        // Full cycle with stop pulsed during phase 2: ends after this cycle.
        i_start = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            check_step("stop_cyc", k, exp_phase[k], 1'b1, (k == 11));
            if (k == 0) i_start = 1'b0;
            if (k == 6) i_stop = 1'b1;
            if (k == 7) i_stop = 1'b0;
        end
        tick();
        check_idle("stop_done");
        tick();
        check_idle("stop_hold");

        // Start and stop on the same idle clock: exactly one cycle.
        i_start = 1'b1;
        i_stop  = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (k == 0) begin
                i_start = 1'b0;
                i_stop  = 1'b0;
            end
            check_step("one_cyc", k, exp_phase[k], 1'b1, (k == 11));
        end
        tick();
        check_idle("one_done");

        // Immediate stop during phase 1; start edge while stopped is ignored.
        i_start = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (k == 0) i_start = 1'b0;
            check_step("dc_run", k, exp_phase[k], 1'b1, 1'b0);
        end
        i_dc_stop = 1'b0;
        tick();
        check_idle("dc_stop");
        i_start = 1'b1;
        tick();
        check_idle("dc_start_ign");
        tick();
        i_dc_stop = 1'b1;
        tick();
        check_idle("dc_release");
        i_start = 1'b0;
        tick();
        check_idle("dc_after");

        // Reset mid-pulse with start held high; restart needs a fresh edge.
        i_start = 1'b1;
        tick();
        check_step("rst_run", 0, 4'h1, 1'b1, 1'b0);
        i_reset = 1'b1;
        tick();
        check_idle("rst_mid");
        i_reset = 1'b0;
        repeat (3) tick();
        check_idle("rst_held");
        i_start = 1'b0;
        tick();
        check_idle("rst_low");

        // Fresh edge restarts; without stop the ring wraps into a new cycle.
        i_start = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (k == 0) i_start = 1'b0;
            check_step("free", k, exp_phase[k], 1'b1, (k == 11));
        end
        tick();
        check_step("wrap", 0, 4'h1, 1'b1, 1'b0);
        i_dc_stop = 1'b0;
        tick();
        check_idle("wrap_kill");
        i_dc_stop = 1'b1;
        tick();

`ifdef TIMING_RING_STEP_EN
        // Step mode: ring waits at the end of each gap until an i_step edge.
        i_step_mode = 1'b1;
        i_start     = 1'b1;
        tick();
        i_start = 1'b0;
        check_step("step", 0, 4'h1, 1'b1, 1'b0);
        tick();
        check_step("step", 1, 4'h1, 1'b1, 1'b0);
        for (int k = 2; k < 5; k++) begin
            tick();
            check_step("step_wait", k, 4'h0, 1'b1, 1'b0);
        end
        i_step = 1'b1;
        tick();
        i_step = 1'b0;
        check_step("step", 5, 4'h2, 1'b1, 1'b0);
        tick();
        check_step("step", 6, 4'h2, 1'b1, 1'b0);
        repeat (2) tick();
        check_step("step_wait", 8, 4'h0, 1'b1, 1'b0);
        i_step = 1'b1;
        tick();
        i_step = 1'b0;
        check_step("step", 9, 4'h4, 1'b1, 1'b0);
        i_dc_stop = 1'b0;
        tick();
        check_idle("step_kill");
        i_dc_stop   = 1'b1;
        i_step_mode = 1'b0;
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/timing_ring.md
TIMING_RING -- requirements
Module: timing_ring

Interface
REQ-001 SHALL have parameter PHASES, default 4, meaning number of ring phases (2..16).
REQ-002 SHALL have parameter WIDTH, default 2, meaning clocks each phase pulse is high (>=1).
REQ-003 SHALL have parameter GAP, default 1, meaning all-low clocks between consecutive phase pulses (>=1).
REQ-004 SHALL have ports: i_clk  in  1  single clock, all logic on posedge.
REQ-005 SHALL have ports: i_reset  in  1  synchronous active-high reset.
REQ-006 SHALL have ports: i_start  in  1  start request, acts on rising edge only (positive AC pulse).
REQ-007 SHALL have ports: i_stop  in  1  stop request, level, honoured at end of ring cycle.
REQ-008 SHALL have ports: i_dc_stop  in  1  active-low immediate stop.
REQ-009 SHALL have ports: o_phase  out  PHASES  positive phase pulses for trigger AC set/reset inputs.
REQ-010 SHALL have ports: o_running  out  1  high while ring not IDLE.
REQ-011 SHALL have ports: o_cycle_end  out  1  one-clock pulse at completion of the last phase's gap.

Function
REQ-012 SHALL implement states IDLE, PULSE, GAP; phase index idx 0..PHASES-1; cycle counter cnt.
REQ-013 SHALL detect start as i_start high with previous-clock i_start low (registered last_start).
REQ-014 SHALL, in IDLE on start edge at clock n, enter PULSE with idx=0 so o_phase[0]=1 from clock n+1.
REQ-015 SHALL hold o_phase[idx]=1 for exactly WIDTH clocks in PULSE, then enter GAP with o_phase all zero.
REQ-016 SHALL hold GAP exactly GAP clocks, then advance idx by one and enter PULSE.
REQ-017 SHALL, at GAP end with idx=PHASES-1, wrap idx to 0, pulse o_cycle_end for one clock, and enter IDLE if stop pending else PULSE.
REQ-018 SHALL latch i_stop high into stop_pending at any non-IDLE clock; clear it on entry to IDLE.
REQ-019 SHALL treat start edge and i_stop high on same IDLE clock as start plus stop pending: exactly one full ring cycle.
REQ-020 SHALL ignore start edges while not IDLE.
REQ-021 SHALL, when i_dc_stop low, force IDLE next clock: o_phase zero, idx 0, stop_pending clear, o_cycle_end low; overrides all else except reset.
REQ-022 SHALL hold IDLE while i_dc_stop low, even on start edges.
REQ-023 SHALL guarantee at most one o_phase bit high in any clock and at least GAP low clocks between any two pulses.
REQ-024 SHALL drive o_running high in PULSE and GAP only.

Reset
REQ-025 SHALL, on i_reset high, set state IDLE, idx 0, cnt 0, stop_pending 0, last_start 0, o_phase 0, o_running 0, o_cycle_end 0.
REQ-026 SHALL let reset take priority over i_dc_stop and start; reset mid-pulse truncates pulse next clock.
REQ-027 SHALL treat i_start held high through reset release as no edge until it drops and rises.

Configuration
REQ-028 SHALL, with TIMING_RING_STEP_EN defined, add inputs i_step_mode and i_step (both 1 bit).
REQ-029 SHALL, with TIMING_RING_STEP_EN and i_step_mode high, hold in GAP after its GAP clocks until an i_step rising edge, then advance as REQ-016/REQ-017.
REQ-030 SHALL, without TIMING_RING_STEP_EN, omit those ports and free-run per REQ-016.

Structure
REQ-031 SHALL place state encoding typedef (IDLE/PULSE/GAP) and max-PHASES constant in shared package timing_pkg.
REQ-032 SHALL use one sub-module, edge_det (rising-edge detector with registered last value), for i_start and i_step.

Verification
REQ-033 SHALL cover PHASES=4, WIDTH=2, GAP=1: start edge at clk 10 -> o_phase = 1,2,4,8, each 2 clks high, 1 low between; o_phase[0] rises clk 11.
REQ-034 SHALL cover i_stop pulsed during phase 2 -> cycle completes, o_cycle_end high at clk 22, o_running low at clk 23.
REQ-035 SHALL cover i_dc_stop low during phase 1 -> o_phase 0 and o_running 0 next clk; start edge while low ignored.
REQ-036 SHALL cover start edge and i_stop same IDLE clock -> exactly 4 pulses, one o_cycle_end, then IDLE.
REQ-037 SHALL cover i_reset mid-PULSE with i_start held high -> outputs zero next clk; no restart until i_start low then high.
REQ-038 SHALL cover TIMING_RING_STEP_EN, i_step_mode=1 -> after phase 0 gap ring waits; each i_step edge yields next single pulse.
